// File: rtl/paddle_input_ctrl_pkg.sv
// Shared encodings and constants for the paddle input conditioning stage.
// Used by paddle_input_ctrl (optional PADDLE_ACCEL_EN build) and btn_debounce.
package paddle_input_ctrl_pkg;

  localparam int CNT_W      = 24;
  localparam int SPEED_BASE = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef logic [1:0] dir_t;
  localparam dir_t DIR_NONE  = 2'd0;
  localparam dir_t DIR_LEFT  = 2'd1;
  localparam dir_t DIR_RIGHT = 2'd2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FIRST  = 2'd1;
  localparam state_t ST_DELAY  = 2'd2;
  localparam state_t ST_REPEAT = 2'd3;

endpackage

// File: rtl/paddle_input_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a stable-run debounce counter.
// The level toggles after DEBOUNCE_CYCLES consecutive samples that disagree with it.
module btn_debounce
  import paddle_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Paddle button conditioning: debounced levels plus step pulses with auto-repeat.
// Define PADDLE_ACCEL_EN to halve the repeat period after 8 repeat steps.
module paddle_input_ctrl
  import paddle_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int STEP_UNIT       = 250000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       to_left,
  input  logic       to_right,
  input  logic [3:0] bar_move_speed,
  input  logic       lose,
  output logic       step_left,
  output logic       step_right,
  output logic       left_level,
  output logic       right_level
);

  // Handshake-free block: step_left/step_right are single-cycle strobes with no
  // back-pressure; the consumer must act on every cycle a strobe is high.

  state_t state;
  dir_t   cur_dir;
  dir_t   dir;
  cnt_t   cnt;
  cnt_t   period;
  cnt_t   period_eff;
  logic   rep_fire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk  (mclk),
    .rst  (rst),
    .btn  (to_left),
    .level(left_level)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk  (mclk),
    .rst  (rst),
    .btn  (to_right),
    .level(right_level)
  );

  always_comb begin
    dir = DIR_NONE;
    if (left_level && !right_level) begin
      dir = DIR_LEFT;
    end else if (right_level && !left_level) begin
      dir = DIR_RIGHT;
    end
  end

  // Speed is only consumed on a reload, so mid-period changes wait for the next period.
  assign period = (cnt_t'(SPEED_BASE) - cnt_t'(bar_move_speed)) * cnt_t'(STEP_UNIT);

`ifdef PADDLE_ACCEL_EN
  logic [2:0] accel_cnt;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      accel_cnt <= '0;
    end else if (rep_fire) begin
      if (accel_cnt != 3'd7) accel_cnt <= accel_cnt + 3'd1;
    end else if (state != ST_REPEAT) begin
      accel_cnt <= '0;
    end
  end

  always_comb begin
    period_eff = period;
    if (accel_cnt == 3'd7) begin
      period_eff = ((period >> 1) == '0) ? cnt_t'(1) : (period >> 1);
    end
  end
`else
  assign period_eff = period;
`endif

  // A repeat step fires when the running count expires and the held direction is unchanged.
  assign rep_fire = !lose && (dir == cur_dir) && (cnt == '0) &&
                    (((state == ST_DELAY) && (bar_move_speed != 4'd0)) || (state == ST_REPEAT));

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_dir    <= DIR_NONE;
      cnt        <= '0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
    end else begin
      step_left  <= 1'b0;
      step_right <= 1'b0;
      if (lose || ((state != ST_IDLE) && (dir != cur_dir))) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dir != DIR_NONE) begin
              state      <= ST_FIRST;
              cur_dir    <= dir;
              cnt        <= cnt_t'(REPEAT_DELAY - 1);
              step_left  <= (dir == DIR_LEFT);
              step_right <= (dir == DIR_RIGHT);
            end
          end
          ST_FIRST: begin
            state <= ST_DELAY;
            if (cnt != '0) cnt <= cnt - cnt_t'(1);
          end
          default: begin
            // DELAY parks at zero while speed is 0; REPEAT always reloads at zero.
            if (rep_fire) begin
              state      <= ST_REPEAT;
              cnt        <= period_eff - cnt_t'(1);
              step_left  <= (cur_dir == DIR_LEFT);
              step_right <= (cur_dir == DIR_RIGHT);
            end else if (cnt != '0) begin
              cnt <= cnt - cnt_t'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/paddle_input_ctrl.md
Name: paddle_input_ctrl

Overview:
- Upstream conditioning stage for the paddle-bar controls that feed the VGA display block.
- Synchronises and debounces raw to_left/to_right buttons, then emits one-cycle step pulses with press-and-hold auto-repeat.
- Repeat rate is set by bar_move_speed. Steps are frozen while the display reports lose.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a debounced level changes (10 ms @ 50 MHz)
REPEAT_DELAY, 15000000, cycles from the first step to the first auto-repeat step (300 ms)
STEP_UNIT, 250000, cycles per repeat-period unit (5 ms)

Ports:
mclk  input  1  system clock
rst  input  1  asynchronous, active-low reset
to_left  input  1  raw left button, asynchronous to mclk
to_right  input  1  raw right button, asynchronous to mclk
bar_move_speed  input  4  repeat speed; 0 = auto-repeat disabled, 15 = fastest
lose  input  1  game-over flag from display; suppresses all steps while high
step_left  output  1  one-cycle pulse: move bar one step left
step_right  output  1  one-cycle pulse: move bar one step right
left_level  output  1  debounced left button level
right_level  output  1  debounced right button level

Behaviour:
- Reset (rst low, async): all outputs 0; synchronisers, debounce counters and repeat counter cleared; FSM in IDLE.
- Synchronisation: each button passes through a 2-FF synchroniser before debounce.
- Debounce, per button:
  - Counter resets whenever the synced input equals the current level.
  - Otherwise it counts; when it reaches DEBOUNCE_CYCLES-1 the level toggles and the counter clears.
  - Latency from a clean input edge to the level change is 2 + DEBOUNCE_CYCLES cycles.
- Direction: dir = LEFT if left_level & !right_level; RIGHT if right_level & !left_level; otherwise NONE. Both buttons held counts as NONE.
- FSM states: IDLE, FIRST, DELAY, REPEAT.
  - IDLE -> FIRST on dir != NONE.
  - FIRST lasts exactly one cycle; it asserts the step pulse for dir and loads the counter with REPEAT_DELAY-1, then -> DELAY.
  - DELAY decrements the counter. At 0: -> REPEAT if bar_move_speed != 0, else stay in DELAY (no further steps).
  - REPEAT asserts the step pulse on entry. The counter reloads with (16 - bar_move_speed)*STEP_UNIT - 1, using a 24-bit unsigned product. At 0 it pulses again and reloads.
- bar_move_speed is sampled only at each reload. A change mid-period takes effect on the next period.
- A dir change to NONE or to the opposite direction in any state -> IDLE that cycle with no pulse. An opposite direction re-enters FIRST on the following cycle.
- lose high:
  - step_left and step_right are forced to 0.
  - FSM held in IDLE; the debounce logic keeps running.
  - After lose falls, a still-held button produces its FIRST pulse one cycle later.
- step_left and step_right are registered and never high together. First-step latency is 1 cycle after the debounced level rises.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined:
  - A 3-bit saturating counter counts REPEAT pulses.
  - After 8 repeats the reload value is halved (logical shift right by 1, minimum 1 cycle).
  - The counter clears on leaving REPEAT.
- Undefined: the repeat period is constant and no accel counter is synthesised.

Decomposition:
- Shared package holds:
  - direction encoding (NONE/LEFT/RIGHT)
  - FSM state encoding
  - the 24-bit counter width constant
  - the speed-to-period formula constant 16
- One sub-module, btn_debounce (synchroniser plus debounce counter), is instantiated twice.
- The FSM and repeat counter stay in the top module.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, STEP_UNIT=2.
- Glitch rejection: a to_left pulse of 3 cycles -> left_level stays 0 and there is no step_left.
- Single press: to_left held 10 cycles, bar_move_speed=0 -> left_level rises 6 cycles after the edge; exactly one step_left pulse, one cycle later.
- Auto-repeat: to_right held 100 cycles, bar_move_speed=14 -> first pulse; second pulse 20 cycles later; further pulses every 4 cycles.
- Both held: to_left held, then to_right also asserted -> steps stop once right_level rises. Releasing to_left -> step_right FIRST pulse one cycle after left_level falls.
- Lose freeze: lose=1 while to_left is held with speed 15 -> no steps. lose falls -> step_left pulse one cycle later.
- Reset mid-repeat: rst low during REPEAT -> all outputs 0 immediately. On release with the button held, left_level re-qualifies after 6 cycles, then a FIRST pulse follows.
